// File: rtl/uart_rx_fifo_if.sv
// Receive-side FIFO bus: receiver hand-off, CPU pop port and status/overrun flags.
// Latency: n/a (signal bundle only).
// Backpressure: none here; the receiver stays held by its done level until the FIFO clears it.
// Ports (slave = FIFO side):
//   i_rxdata/i_rxerr/i_rxdone  receiver frame and frame-complete level
//   o_rxclear                  receiver re-arm pulse
//   i_rd, o_rdata/o_rderr      pop request and head entry
//   o_empty/o_full/o_count     occupancy
//   o_overrun/i_ovclear        sticky drop flag and its clear
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic [7:0]          i_rxdata;
  logic                i_rxerr;
  logic                i_rxdone;
  logic                o_rxclear;
  logic                i_rd;
  logic [7:0]          o_rdata;
  logic                o_rderr;
  logic                o_empty;
  logic                o_full;
  logic [DEPTH_LOG2:0] o_count;
  logic                o_overrun;
  logic                i_ovclear;

  modport slave (
    input  i_rxdata, i_rxerr, i_rxdone, i_rd, i_ovclear,
    output o_rxclear, o_rdata, o_rderr, o_empty, o_full, o_count, o_overrun
  );

  modport master (
    output i_rxdata, i_rxerr, i_rxdone, i_rd, i_ovclear,
    input  o_rxclear, o_rdata, o_rderr, o_empty, o_full, o_count, o_overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures finished frames, re-arms the receiver, queues frames in a FWFT FIFO.
// Latency: entry written on the capture edge, visible (o_empty=0) and o_rxclear high the next cycle.
// Backpressure: a frame arriving while full is dropped (unless popped the same cycle) and sets o_overrun.
// Ports: i_clk, i_reset (synchronous, active-high), bus (uart_rx_fifo_if.slave).
// Optional build macro UART_RX_FIFO_ERRDROP_EN: errored frames are discarded, entries are 8 bits
// and o_rderr is tied low. Without it errored frames are stored with their error flag.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
`ifdef UART_RX_FIFO_ERRDROP_EN
  localparam int EW = 8;
`else
  localparam int EW = 9;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                state;
  logic                  rxclear;
  logic                  overrun;
  logic [EW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;

  logic          capture;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [EW-1:0] wr_entry;

  always_comb begin
    capture = (state == S_IDLE) && bus.i_rxdone;
`ifdef UART_RX_FIFO_ERRDROP_EN
    push_req = capture && !bus.i_rxerr;
    wr_entry = bus.i_rxdata;
`else
    push_req = capture;
    wr_entry = {bus.i_rxerr, bus.i_rxdata};
`endif
    full  = (count == DEPTH_CNT);
    empty = (count == '0);
    pop   = bus.i_rd && !empty;
    // When full, a same-cycle pop frees the slot the new frame lands in.
    push  = push_req && (!full || bus.i_rd);
    drop  = push_req && full && !bus.i_rd;
  end

  // Capture FSM. WAIT holds off until the receiver drops done so one
  // frame is never captured twice.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_IDLE;
      rxclear <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          rxclear <= 1'b0;
          if (bus.i_rxdone) begin
            state   <= S_CLEAR;
            rxclear <= 1'b1;
          end
        end
        S_CLEAR: begin
          state   <= S_WAIT;
          rxclear <= 1'b0;
        end
        S_WAIT: begin
          rxclear <= 1'b0;
          if (!bus.i_rxdone) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          rxclear <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new overrun beats a same-cycle clear.
      if (drop)               overrun <= 1'b1;
      else if (bus.i_ovclear) overrun <= 1'b0;
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push && !i_reset) mem[wr_ptr] <= wr_entry;
  end

  assign bus.o_rxclear = rxclear;
  assign bus.o_empty   = empty;
  assign bus.o_full    = full;
  assign bus.o_count   = count;
  assign bus.o_overrun = overrun;
  // Head is forced to zero while empty so the outputs read 0 out of reset.
  assign bus.o_rdata   = empty ? 8'h00 : mem[rd_ptr][7:0];
`ifdef UART_RX_FIFO_ERRDROP_EN
  assign bus.o_rderr   = 1'b0;
`else
  assign bus.o_rderr   = empty ? 1'b0 : mem[rd_ptr][8];
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus scoreboard monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_fifo;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL)) bus ();
  uart_rx_fifo #(.DEPTH_LOG2(DL)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [8:0] sb_q[$];
  int  m_cnt   = 0;
  bit  m_ov    = 0;
  bit  armed   = 1;
  int  cap_cyc = -10;
  int  cyc     = 0;
  bit  started = 0;

  // Stimulus controls for the pop/overrun-clear driver
  bit rd_force = 0;
  bit ov_force = 0;
  int rd_pct   = 0;
  int ov_pct   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // i_rd / i_ovclear driver, runs 1 time unit after the directed code each cycle.
  initial begin
    bus.i_rd      = 1'b0;
    bus.i_ovclear = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.i_rd      = rd_force || (int'($urandom_range(99)) < rd_pct);
      bus.i_ovclear = ov_force || (int'($urandom_range(99)) < ov_pct);
    end
  end

  // Reference model: plain FIFO occupancy and a rule-level view of when a frame is taken.
  always @(posedge clk) begin
    bit pop;
    bit cap;
    bit push_req;
    bit ov_set;
    cyc++;
    if (rst) begin
      m_cnt   = 0;
      m_ov    = 0;
      armed   = 1;
      cap_cyc = -10;
      sb_q.delete();
      started = 1;
    end else if (started) begin
      pop = bus.i_rd && (m_cnt > 0);
      cap = armed && bus.i_rxdone;
      ov_set = 0;
      if (cap) begin
        armed   = 0;
        cap_cyc = cyc;
      end else if (!armed && !bus.i_rxdone && cyc >= cap_cyc + 2) begin
        armed = 1;
      end
`ifdef UART_RX_FIFO_ERRDROP_EN
      push_req = cap && !bus.i_rxerr;
`else
      push_req = cap;
`endif
      if (push_req) begin
        if (m_cnt < DEPTH) begin
`ifdef UART_RX_FIFO_ERRDROP_EN
          sb_q.push_back({1'b0, bus.i_rxdata});
`else
          sb_q.push_back({bus.i_rxerr, bus.i_rxdata});
`endif
          m_cnt = m_cnt + 1 - int'(pop);
        end else if (pop) begin
          sb_q.push_back({
`ifdef UART_RX_FIFO_ERRDROP_EN
            1'b0,
`else
            bus.i_rxerr,
`endif
            bus.i_rxdata});
        end else begin
          ov_set = 1;
        end
      end else begin
        m_cnt = m_cnt - int'(pop);
      end
      if (ov_set) m_ov = 1;
      else if (bus.i_ovclear) m_ov = 0;
    end
  end

  // Monitor: status every cycle, and head data whenever a pop is about to be taken.
  always @(negedge clk) begin
    logic [8:0] e;
    if (started) begin
      check("count",   int'(bus.o_count),   m_cnt);
      check("empty",   int'(bus.o_empty),   int'(m_cnt == 0));
      check("full",    int'(bus.o_full),    int'(m_cnt == DEPTH));
      check("overrun", int'(bus.o_overrun), int'(m_ov));
      check("rxclear", int'(bus.o_rxclear), int'(cyc == cap_cyc));
      if (bus.i_rd && !rst && !bus.o_empty) begin
        check("sb_has_entry", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("rdata", int'(bus.o_rdata), int'(e[7:0]));
          check("rderr", int'(bus.o_rderr), int'(e[8]));
        end
      end
    end
  end

  // Receiver model: raise done with a frame, wait for the clear, hold, drop, allow re-arm.
  task automatic send(input logic [7:0] d, input bit er, input int hold,
                      input bit with_rd, input bit with_ov);
    int t;
    bus.i_rxdata = d;
    bus.i_rxerr  = er;
    bus.i_rxdone = 1'b1;
    rd_force     = with_rd;
    ov_force     = with_ov;
    step();
    rd_force = 0;
    ov_force = 0;
    t = 0;
    @(negedge clk);
    while (!bus.o_rxclear && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) check("rxclear_seen", int'(bus.o_rxclear), 1);
    repeat (hold) @(posedge clk);
    step();
    bus.i_rxdone = 1'b0;
    step();
  endtask

  task automatic drain(input int n);
    rd_force = 1;
    repeat (n) step();
    rd_force = 0;
    step();
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) send(8'(base + i), 0, 0, 0, 0);
  endtask

  initial begin
    int t;
    bus.i_rxdata = 8'h00;
    bus.i_rxerr  = 1'b0;
    bus.i_rxdone = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_rdata", int'(bus.o_rdata), 0);
    check("reset_rderr", int'(bus.o_rderr), 0);
    check("reset_empty", int'(bus.o_empty), 1);
    step();

    // Single frame
    send(8'hA5, 0, 0, 0, 0);
    @(negedge clk);
    check("a5_count", int'(bus.o_count), 1);
    check("a5_rdata", int'(bus.o_rdata), 'hA5);
    check("a5_rderr", int'(bus.o_rderr), 0);
    step();
    drain(1);
    @(negedge clk);
    check("a5_popped_empty", int'(bus.o_empty), 1);
    step();

    // Fill, overflow, drain in order
    fill(DEPTH, 0);
    @(negedge clk);
    check("fill_full", int'(bus.o_full), 1);
    check("fill_count", int'(bus.o_count), DEPTH);
    step();
    send(8'h08, 0, 0, 0, 0);
    @(negedge clk);
    check("ovf_overrun", int'(bus.o_overrun), 1);
    check("ovf_count", int'(bus.o_count), DEPTH);
    step();
    drain(DEPTH);
    ov_force = 1; step(); ov_force = 0; step();

    // Full plus same-cycle pop and push
    fill(DEPTH, 'h10);
    send(8'h55, 0, 0, 1, 0);
    @(negedge clk);
    check("fullrd_count", int'(bus.o_count), DEPTH);
    check("fullrd_overrun", int'(bus.o_overrun), 0);
    step();
    drain(DEPTH);

    // Push and pop together on empty FIFO
    send(8'h66, 0, 0, 1, 0);
    @(negedge clk);
    check("emptyrd_count", int'(bus.o_count), 1);
    step();
    drain(1);

    // Long done: one capture only, then a second frame
    send(8'h11, 0, 9, 0, 0);
    @(negedge clk);
    check("longdone_count", int'(bus.o_count), 1);
    step();
    send(8'h12, 0, 0, 0, 0);
    @(negedge clk);
    check("second_count", int'(bus.o_count), 2);
    step();
    drain(2);

    // Framing error
    send(8'h3C, 1, 0, 0, 0);
    @(negedge clk);
`ifdef UART_RX_FIFO_ERRDROP_EN
    check("err_dropped_empty", int'(bus.o_empty), 1);
`else
    check("err_rdata", int'(bus.o_rdata), 'h3C);
    check("err_rderr", int'(bus.o_rderr), 1);
`endif
    step();
    drain(1);

    // Overrun with simultaneous clear, then clear alone
    fill(DEPTH, 'h20);
    send(8'h77, 0, 0, 0, 0);
    send(8'h78, 0, 0, 0, 1);
    @(negedge clk);
    check("ov_set_wins", int'(bus.o_overrun), 1);
    step();
    ov_force = 1; step(); ov_force = 0;
    @(negedge clk);
    check("ov_cleared", int'(bus.o_overrun), 0);
    step();
    drain(DEPTH);

    // Reset while in WAIT with 3 entries; still-high done is re-captured afterwards
    fill(3, 'h30);
    bus.i_rxdata = 8'h44;
    bus.i_rxerr  = 1'b0;
    bus.i_rxdone = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_count", int'(bus.o_count), 0);
    t = 0;
    while (!bus.o_rxclear && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_recapture_clear", int'(bus.o_rxclear), 1);
    step();
    bus.i_rxdone = 1'b0;
    step();
    step();
    drain(1);

    // Randomised traffic at several drain rates
    ov_pct = 5;
    for (int ph = 0; ph < 3; ph++) begin
      rd_pct = (ph == 0) ? 10 : (ph == 1) ? 50 : 90;
      for (int i = 0; i < 60; i++) begin
        send(8'($urandom), $urandom_range(3) == 0, int'($urandom_range(3)), 0, 0);
        repeat ($urandom_range(2)) step();
      end
    end
    rd_pct = 0;
    ov_pct = 0;
    step();
    drain(DEPTH + 2);
    @(negedge clk);
    check("final_empty", int'(bus.o_empty), 1);
    check("final_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. It captures each completed frame (data byte plus framing-error flag) when the receiver reports done. It then re-arms the receiver with a one-cycle clear pulse and queues the frame in a first-word-fall-through FIFO for the CPU peripheral interface. Overflow is reported through a sticky overrun flag.

## Interface
- DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries); legal range 1–6.

- i_clk  in  1  system clock
- i_reset  in  1  reset, synchronous, active-high
- i_rxdata  in  8  received byte from receiver (valid while i_rxdone=1)
- i_rxerr  in  1  framing error of received byte (valid while i_rxdone=1)
- i_rxdone  in  1  receiver frame-complete level; stays high until receiver is cleared
- o_rxclear  out  1  receiver clear/re-arm pulse, active-high, registered
- i_rd  in  1  pop request, one entry per cycle it is high
- o_rdata  out  8  head entry data (valid when o_empty=0)
- o_rderr  out  1  head entry framing-error flag
- o_empty  out  1  FIFO empty
- o_full  out  1  FIFO full
- o_count  out  DEPTH_LOG2+1  number of stored entries, 0..2^DEPTH_LOG2
- o_overrun  out  1  sticky: frame arrived while full and was dropped
- i_ovclear  in  1  clears o_overrun

## Operation
- Storage: 2^DEPTH_LOG2 × 9-bit entries {err, data}. Write and read pointers are DEPTH_LOG2 bits wide and wrap modulo depth. Count is tracked separately.
- Capture FSM, 3 states:
  - IDLE: on i_rxdone=1, push {i_rxerr, i_rxdata} and go to CLEAR.
  - CLEAR: o_rxclear=1 for exactly this cycle; unconditionally go to WAIT.
  - WAIT: stay until i_rxdone=0, then go to IDLE. This prevents double capture of one frame.
  - Illegal encodings go to IDLE.
- Push acceptance:
  - Accepted if not full, or if full and i_rd=1 in the same cycle; in the full case count is unchanged.
  - Otherwise the frame is dropped and o_overrun is set. The receiver is still cleared.
- Pop: i_rd=1 with o_empty=0 advances the read pointer. i_rd with o_empty=1 is ignored; no pointer or count change.
- Simultaneous push and pop on an empty FIFO: the push is accepted, the pop is ignored, and count becomes 1.
- o_rdata/o_rderr are driven combinationally from the head entry. Contents are don't-care when empty.
- o_overrun: if set and i_ovclear occur in the same cycle, set wins.
- o_empty = (count==0); o_full = (count==2^DEPTH_LOG2).

## Timing
- Reset values: o_rxclear=0, o_empty=1, o_full=0, o_count=0, o_overrun=0, o_rderr=0, o_rdata=0. FSM=IDLE, pointers=0.
- i_rxdone sampled 1 at edge N:
  - Entry is written at edge N.
  - o_empty=0 and o_count incremented from cycle N+1.
  - o_rxclear=1 during cycle N+1 only.
- The receiver drops i_rxdone after the clear. The FSM returns to IDLE on the first edge with i_rxdone=0, so the earliest next capture is 3 cycles after the previous one.
- Pop at edge M: the new head is visible and o_count is decremented in cycle M+1.
- Reset asserted mid-frame or in CLEAR/WAIT: the FIFO is flushed and the FSM goes to IDLE on that edge. A still-high i_rxdone after reset is captured as a new frame.

## Configuration
- UART_RX_FIFO_ERRDROP_EN defined:
  - Frames with i_rxerr=1 are not pushed, but the receiver is still cleared via CLEAR/WAIT.
  - Such frames never set o_overrun.
  - o_rderr is tied 0 and entries are 8 bits wide.
- Undefined: errored frames are stored with the error flag set, as described above.

## Test plan
- Reset, then receiver done with 0xA5, err=0:
  - o_rxclear pulses 1 cycle.
  - o_empty=0, o_count=1, o_rdata=0xA5, o_rderr=0.
  - i_rd pop gives o_empty=1.
- 8 frames 0x00..0x07 (DEPTH_LOG2=3) with no reads:
  - o_full=1, o_count=8.
  - A 9th frame 0x08 sets o_overrun and is dropped.
  - Popping all 8 yields 0x00..0x07 in order.
- Full FIFO, frame 0x55 arrives in the same cycle as i_rd:
  - Accepted, o_count stays 8, o_overrun stays 0.
  - The last entry popped is 0x55.
- i_rxdone held high 10 cycles:
  - Exactly one push and one o_rxclear pulse.
  - A second done after the drop gives a second push.
- Framing error, frame 0x3C with err=1:
  - Macro undefined: o_rdata=0x3C, o_rderr=1.
  - Macro defined: o_empty remains 1 and o_rxclear still pulses.
- o_overrun set, then i_ovclear asserted in the same cycle as a new overrun: o_overrun stays 1. A later i_ovclear alone clears it. Reset during WAIT with 3 entries gives o_count=0.
